// File: rtl/upsample_nx_if.sv
// Stream bundle for upsample_nx: input beats in, upsampled beats out.
interface upsample_nx_if #(
    parameter int FTW = 32
);
    logic [FTW-1:0] feature;
    logic           feature_valid;
    logic           feature_ready;
    logic [FTW-1:0] upsample_feature;
    logic           upsample_valid;
    logic           output_ready;

    modport slave (
        input  feature, feature_valid, output_ready,
        output feature_ready, upsample_feature, upsample_valid
    );
    modport master (
        output feature, feature_valid, output_ready,
        input  feature_ready, upsample_feature, upsample_valid
    );
endinterface

// File: rtl/upsample_nx.sv
// Nearest-neighbour x1/x2/x4 upsampler with one-row line RAM.
// Optional zero insertion for transposed conv: define UPSAMPLE_ZERO_INSERT_EN.
module upsample_nx_lane #(
    parameter int W = 8
) (
    input  logic         system_clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         zero,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    always_ff @(posedge system_clk) begin
        if (!rst_n)  dout <= '0;
        else if (en) dout <= zero ? '0 : din;
    end
endmodule

module upsample_nx #(
    parameter int FEATURE_WIDTH       = 8,
    parameter int PE_ARRAY_SIZE       = 4,
    parameter int FEATURE_TOTAL_WIDTH = FEATURE_WIDTH * PE_ARRAY_SIZE,
    parameter int MAX_COL             = 512,
    parameter int SIZE_W              = 10
) (
    input  logic              system_clk,
    input  logic              rst_n,
    upsample_nx_if.slave      s,
    input  logic [SIZE_W-1:0] col_size,
    input  logic [SIZE_W-1:0] row_size,
    input  logic [1:0]        scale_sel,
`ifdef UPSAMPLE_ZERO_INSERT_EN
    input  logic              zero_insert,
`endif
    output logic              frame_done,
    output logic              busy
);
    localparam int CW     = SIZE_W + 2;
    localparam int AW     = $clog2(MAX_COL);
    localparam int STAGES = 2;

    typedef enum logic [1:0] {IDLE, FILL, REPLAY, DONE} state_t;
    state_t state, state_nxt;

    logic [FEATURE_TOTAL_WIDTH-1:0] line_ram [MAX_COL];
    logic [FEATURE_TOTAL_WIDTH-1:0] s1_data;
    logic [CW-1:0] col_last, row_last, s_max;
    logic [CW-1:0] wr_col, rd_col, h_rep, v_rep, row_cnt;
    logic          zi_r, zi_in, issue_done, s1_zero, s1_last, out_last;
    logic [STAGES:1] vld_pipe;

    logic cfg_ok, in_hs, advance, issue, row_done;
    logic wr_last, last_h, last_c, last_v;

`ifdef UPSAMPLE_ZERO_INSERT_EN
    assign zi_in = zero_insert;
`else
    assign zi_in = 1'b0;
`endif

    assign cfg_ok   = (col_size != '0) && (row_size != '0) && (CW'(col_size) <= CW'(MAX_COL));
    assign in_hs    = (state == FILL) && s.feature_valid;
    assign advance  = !vld_pipe[2] || s.output_ready;
    assign issue    = (state == REPLAY) && !issue_done && advance;
    assign row_done = vld_pipe[2] && s.output_ready && out_last;
    assign wr_last  = (wr_col == col_last);
    assign last_h   = (h_rep == s_max);
    assign last_c   = (rd_col == col_last);
    assign last_v   = (v_rep == s_max);

    always_ff @(posedge system_clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_ok) state_nxt = FILL;
            FILL:    if (in_hs && wr_last) state_nxt = REPLAY;
            REPLAY:  if (row_done) state_nxt = (row_cnt == row_last) ? DONE : FILL;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s.feature_ready  = (state == FILL);
        s.upsample_valid = vld_pipe[2];
        frame_done       = (state == DONE);
        busy             = (state != IDLE);
    end

    always_ff @(posedge system_clk) begin
        if (!rst_n) begin
            col_last   <= '0;
            row_last   <= '0;
            s_max      <= '0;
            zi_r       <= 1'b0;
            wr_col     <= '0;
            rd_col     <= '0;
            h_rep      <= '0;
            v_rep      <= '0;
            row_cnt    <= '0;
            issue_done <= 1'b0;
            vld_pipe   <= '0;
            s1_zero    <= 1'b0;
            s1_last    <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                col_last   <= CW'(col_size) - CW'(1);
                row_last   <= CW'(row_size) - CW'(1);
                s_max      <= (scale_sel == 2'd1) ? CW'(1) : (scale_sel == 2'd2) ? CW'(3) : CW'(0);
                zi_r       <= zi_in;
                wr_col     <= '0;
                rd_col     <= '0;
                h_rep      <= '0;
                v_rep      <= '0;
                row_cnt    <= '0;
                issue_done <= 1'b0;
            end
            if (in_hs) wr_col <= wr_last ? '0 : wr_col + CW'(1);
            // h_rep innermost, then column, then vertical pass
            if (issue) begin
                h_rep <= last_h ? '0 : h_rep + CW'(1);
                if (last_h) begin
                    rd_col <= last_c ? '0 : rd_col + CW'(1);
                    if (last_c) begin
                        v_rep <= last_v ? '0 : v_rep + CW'(1);
                        if (last_v) issue_done <= 1'b1;
                    end
                end
            end
            if (row_done) begin
                issue_done <= 1'b0;
                row_cnt    <= (row_cnt == row_last) ? '0 : row_cnt + CW'(1);
            end
            if (advance) begin
                vld_pipe[1] <= issue;
                vld_pipe[2] <= vld_pipe[1];
                s1_zero     <= zi_r && ((h_rep != '0) || (v_rep != '0));
                s1_last     <= last_h && last_c && last_v;
                out_last    <= s1_last;
            end
        end
    end

    // line RAM with registered read: the prefetch stage of the output pipe
    always_ff @(posedge system_clk) begin
        if (in_hs) line_ram[wr_col[AW-1:0]] <= s.feature;
        if (issue) s1_data <= line_ram[rd_col[AW-1:0]];
    end

    logic [PE_ARRAY_SIZE-1:0][FEATURE_WIDTH-1:0] s1_lanes, out_lanes;
    assign s1_lanes           = s1_data;
    assign s.upsample_feature = out_lanes;

    for (genvar l = 0; l < PE_ARRAY_SIZE; l++) begin : g_lane
        upsample_nx_lane #(.W(FEATURE_WIDTH)) u_lane (
            .system_clk (system_clk),
            .rst_n      (rst_n),
            .en         (advance && vld_pipe[1]),
            .zero       (s1_zero),
            .din        (s1_lanes[l]),
            .dout       (out_lanes[l])
        );
    end
endmodule

// File: tb/tb_upsample_nx.sv
// Directed bench for upsample_nx: hand vectors, backpressure, bad configs, mid-frame reset.
module tb_upsample_nx;
    localparam int FW = 8, PE = 4, FTW = FW * PE, MAXC = 512, SW = 10;

    logic          system_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [SW-1:0] col_size = '0, row_size = '0;
    logic [1:0]    scale_sel = '0;
    logic          zero_insert = 1'b0;
    logic          frame_done, busy;

    upsample_nx_if #(.FTW(FTW)) bif ();

    upsample_nx #(.FEATURE_WIDTH(FW), .PE_ARRAY_SIZE(PE), .MAX_COL(MAXC), .SIZE_W(SW)) dut (
        .system_clk  (system_clk),
        .rst_n       (rst_n),
        .s           (bif),
        .col_size    (col_size),
        .row_size    (row_size),
        .scale_sel   (scale_sel),
`ifdef UPSAMPLE_ZERO_INSERT_EN
        .zero_insert (zero_insert),
`endif
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 system_clk = ~system_clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, done_cnt = 0, stall_err = 0, first_vld_cyc = -1, acc0 = 0;
    bit rnd_ready = 1'b0, hold_prev = 1'b0;
    logic [FTW-1:0] prev_data;
    logic [FTW-1:0] got[$];
    int beat_cyc[$];

    localparam logic [FTW-1:0] A = 32'hA1, B = 32'hB2, C = 32'hC3, D = 32'hD4, E = 32'hE5, F = 32'hF6;
    logic [FTW-1:0] exp1 [24] = '{A,A,B,B,C,C,A,A,B,B,C,C, D,D,E,E,F,F,D,D,E,E,F,F};
    logic [FTW-1:0] exp2 [8]  = '{A,A,A,A,B,B,B,B};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge system_clk) cyc++;

    initial begin
        bif.output_ready = 1'b1;
        forever begin
            @(posedge system_clk);
            #1 bif.output_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge system_clk) begin
        if (bif.upsample_valid && bif.output_ready) begin
            got.push_back(bif.upsample_feature);
            beat_cyc.push_back(cyc);
        end
        if (bif.upsample_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (frame_done) done_cnt++;
        if (hold_prev && (!bif.upsample_valid || bif.upsample_feature != prev_data)) stall_err++;
        hold_prev = bif.upsample_valid && !bif.output_ready;
        prev_data = bif.upsample_feature;
    end

    task automatic push(input logic [FTW-1:0] d);
        int n = 0;
        while (!bif.feature_ready && n < 5000) begin
            @(negedge system_clk);
            n++;
        end
        if (n >= 5000) check("push_timeout", 0, 1);
        bif.feature       = d;
        bif.feature_valid = 1'b1;
        @(negedge system_clk);
        bif.feature_valid = 1'b0;
    endtask

    task automatic run_frame(input int col, input int row, input int sc, input bit zi,
                             input logic [FTW-1:0] din[$]);
        int n = 0, d0 = done_cnt;
        got.delete();
        beat_cyc.delete();
        first_vld_cyc = -1;
        col_size = SW'(col); row_size = SW'(row); scale_sel = 2'(sc); zero_insert = zi;
        do begin @(negedge system_clk); n++; end while (!busy && n < 10);
        col_size = '0;
        for (int r = 0; r < row; r++) begin
            for (int c = 0; c < col; c++) push(din[r*col + c]);
            if (r == 0) acc0 = cyc;
        end
        n = 0;
        while (done_cnt == d0 && n < 20000) begin @(negedge system_clk); n++; end
        if (n >= 20000) check("frame_timeout", 0, 1);
        repeat (3) @(negedge system_clk);
        check("frame_done_once", done_cnt - d0, 1);
    endtask

    task automatic build_exp(input int col, input int row, input int sc, input bit zi,
                             input logic [FTW-1:0] din[$], output logic [FTW-1:0] q[$]);
        int s = (sc == 1) ? 2 : (sc == 2) ? 4 : 1;
        q.delete();
        for (int r = 0; r < row; r++)
            for (int v = 0; v < s; v++)
                for (int c = 0; c < col; c++)
                    for (int h = 0; h < s; h++)
                        q.push_back((zi && (h != 0 || v != 0)) ? '0 : din[r*col + c]);
    endtask

    task automatic cmp_model(input string tag, input logic [FTW-1:0] q[$]);
        int mism = 0;
        check({tag, "_count"}, got.size(), q.size());
        foreach (q[i]) if (i >= got.size() || got[i] !== q[i]) mism++;
        check({tag, "_data_mismatches"}, mism, 0);
    endtask

    initial begin
        logic [FTW-1:0] din[$];
        logic [FTW-1:0] q[$];
        bif.feature = '0;
        bif.feature_valid = 1'b0;
        repeat (3) @(negedge system_clk);
        rst_n = 1'b1;
        @(negedge system_clk);
        check("rst_valid", bif.upsample_valid, 0);
        check("rst_feature", bif.upsample_feature, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", bif.feature_ready, 0);
        check("rst_done", frame_done, 0);

        // x2, 3x2
        din = '{A, B, C, D, E, F};
        run_frame(3, 2, 1, 1'b0, din);
        check("t1_count", got.size(), 24);
        foreach (exp1[i]) check($sformatf("t1_beat%0d", i), got[i], exp1[i]);
        check("t1_latency", first_vld_cyc - acc0, 2);
        if (beat_cyc.size() >= 12) check("t1_no_bubble", beat_cyc[11] - beat_cyc[0], 11);
        else check("t1_no_bubble_short", beat_cyc.size(), 12);

        // x4, 2x1
        din = '{A, B};
        run_frame(2, 1, 2, 1'b0, din);
        check("t2_count", got.size(), 32);
        for (int i = 0; i < 32; i++) check($sformatf("t2_beat%0d", i), got[i], exp2[i % 8]);

        // x1 pass-through
        din = '{A, B, C, D};
        run_frame(4, 1, 0, 1'b0, din);
        check("t2b_count", got.size(), 4);
        foreach (din[i]) check($sformatf("t2b_beat%0d", i), got[i], din[i]);

        // x2 with random backpressure
        din.delete();
        for (int i = 0; i < 8; i++) din.push_back(32'h3000_0000 + i);
        stall_err = 0;
        rnd_ready = 1'b1;
        run_frame(4, 2, 1, 1'b0, din);
        rnd_ready = 1'b0;
        build_exp(4, 2, 1, 1'b0, din, q);
        cmp_model("t3", q);
        check("t3_stall_hold_errors", stall_err, 0);

        // rejected configs
        foreach (exp2[k]) begin end
        for (int k = 0; k < 2; k++) begin
            got.delete();
            col_size = (k == 0) ? SW'(0) : SW'(MAXC + 1);
            row_size = SW'(1); scale_sel = 2'd1;
            repeat (4) @(negedge system_clk);
            check($sformatf("t4_busy_%0d", k), busy, 0);
            check($sformatf("t4_ready_%0d", k), bif.feature_ready, 0);
            check($sformatf("t4_no_out_%0d", k), got.size(), 0);
        end
        col_size = '0;

        // max columns, x2
        din.delete();
        for (int i = 0; i < MAXC; i++) din.push_back(32'h4000_0000 + i);
        run_frame(MAXC, 1, 1, 1'b0, din);
        build_exp(MAXC, 1, 1, 1'b0, din, q);
        cmp_model("t4_maxcol", q);

        // reset during replay
        begin
            int n = 0;
            col_size = SW'(4); row_size = SW'(2); scale_sel = 2'd1;
            do begin @(negedge system_clk); n++; end while (!busy && n < 10);
            col_size = '0;
            for (int i = 0; i < 4; i++) push(32'h5000_0000 + i);
            n = 0;
            while (!bif.upsample_valid && n < 20) begin @(negedge system_clk); n++; end
            check("t5_reached_replay", bif.upsample_valid, 1);
            @(negedge system_clk);
            rst_n = 1'b0;
            @(negedge system_clk);
            rst_n = 1'b1;
            check("t5_valid_after_rst", bif.upsample_valid, 0);
            check("t5_busy_after_rst", busy, 0);
            repeat (3) @(negedge system_clk);
            din.delete();
            for (int i = 0; i < 4; i++) din.push_back(32'h6000_0000 + i);
            run_frame(4, 1, 1, 1'b0, din);
            build_exp(4, 1, 1, 1'b0, din, q);
            cmp_model("t5_after", q);
        end

`ifdef UPSAMPLE_ZERO_INSERT_EN
        din = '{A, B};
        run_frame(2, 1, 1, 1'b1, din);
        q = '{A, 0, B, 0, 0, 0, 0, 0};
        cmp_model("t6_zero_insert", q);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
